// File: rtl/click_classifier.sv
// Groups debounced press pulses into single/double/triple click events.
// Latency: triple 1 clk after the third press; single/double WINDOW+1 clks after the last press.
// Backpressure: none; every press is accepted and the outputs are unqualified 1-clk pulses.
module click_classifier #(
    parameter int unsigned WINDOW = 30_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       press,
    output logic       single_click,
    output logic       double_click,
    output logic       triple_click,
    output logic       busy,
    output logic [1:0] click_count
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    localparam logic [31:0] LAST = 32'(WINDOW - 1);

    state_t      state, state_nxt;
    logic [1:0]  count, count_nxt;
    logic [31:0] timer, timer_nxt;
    logic        single_nxt, double_nxt, triple_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            count        <= 2'd0;
            timer        <= 32'd0;
            single_click <= 1'b0;
            double_click <= 1'b0;
            triple_click <= 1'b0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            timer        <= timer_nxt;
            single_click <= single_nxt;
            double_click <= double_nxt;
            triple_click <= triple_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        timer_nxt  = timer;
        single_nxt = 1'b0;
        double_nxt = 1'b0;
        triple_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (press) begin
                    count_nxt = 2'd1;
                    timer_nxt = 32'd0;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A press in the timeout cycle still belongs to the open group.
                if (press) begin
                    timer_nxt = 32'd0;
                    if (count == 2'd2) begin
                        triple_nxt = 1'b1;
                        count_nxt  = 2'd0;
                        state_nxt  = ST_IDLE;
                    end else begin
                        count_nxt = count + 2'd1;
                    end
                end else if (timer == LAST) begin
                    single_nxt = (count == 2'd1);
                    double_nxt = (count == 2'd2);
                    count_nxt  = 2'd0;
                    timer_nxt  = 32'd0;
                    state_nxt  = ST_IDLE;
                end else begin
                    timer_nxt = timer + 32'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                count_nxt = 2'd0;
                timer_nxt = 32'd0;
            end
        endcase
    end

    assign busy        = (state == ST_WAIT);
    assign click_count = count;

endmodule

// File: tb/tb_click_classifier.sv
// Directed bench for click_classifier with WINDOW=10; cycle n outputs are sampled 1 ns after edge n.
module tb_click_classifier;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       press = 1'b0;
    logic       single_click, double_click, triple_click, busy;
    logic [1:0] click_count;

    int checks = 0;
    int failures = 0;

    click_classifier #(.WINDOW(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .press        (press),
        .single_click (single_click),
        .double_click (double_click),
        .triple_click (triple_click),
        .busy         (busy),
        .click_count  (click_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int n, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, n, obs, exp);
        end
    endtask

    // Drive press for one cycle, then sample just after the edge.
    task automatic cyc(input logic p);
        press = p;
        @(posedge clk);
        #1;
        press = 1'b0;
    endtask

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] at(input int c);
        return rng(c, c);
    endfunction

    task automatic check_all(input string tag, input int n, input logic s, input logic d,
                             input logic t, input logic b, input logic [1:0] c);
        chk({tag, ".single"}, n, {1'b0, single_click}, {1'b0, s});
        chk({tag, ".double"}, n, {1'b0, double_click}, {1'b0, d});
        chk({tag, ".triple"}, n, {1'b0, triple_click}, {1'b0, t});
        chk({tag, ".busy"},   n, {1'b0, busy},         {1'b0, b});
        chk({tag, ".count"},  n, click_count, c);
    endtask

    // Cycles 0..ncyc-1 are driven; expectations cover outputs in cycles 1..ncyc.
    task automatic run_case(input string tag, input logic [63:0] pm, input int ncyc,
                            input logic [63:0] sm, input logic [63:0] dm, input logic [63:0] tm,
                            input logic [63:0] bm, input logic [63:0] c1m, input logic [63:0] c2m);
        logic [1:0] ce;
        for (int c = 0; c < ncyc; c++) begin
            cyc(pm[c]);
            ce = c2m[c+1] ? 2'd2 : (c1m[c+1] ? 2'd1 : 2'd0);
            check_all(tag, c + 1, sm[c+1], dm[c+1], tm[c+1], bm[c+1], ce);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        check_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        // One press: single at 11, busy 1..10.
        run_case("single", at(0), 14, at(11), '0, '0, rng(1, 10), rng(1, 10), '0);

        // Second press exactly on the window boundary.
        run_case("double_edge", at(0) | at(10), 24, '0, at(21), '0,
                 rng(1, 20), rng(1, 10), rng(11, 20));

        // Third press closes the group immediately.
        run_case("triple", at(0) | at(3) | at(5), 18, '0, '0, at(6),
                 rng(1, 5), rng(1, 3), rng(4, 5));

        // Press one cycle past the window lands in the pulse cycle and opens a new group.
        run_case("late_press", at(0) | at(11), 24, at(11) | at(22), '0, '0,
                 rng(1, 10) | rng(12, 21), rng(1, 10) | rng(12, 21), '0);

        // Third press coincident with the timeout cycle still counts.
        run_case("triple_edge", at(0) | at(10) | at(20), 24, '0, '0, at(21),
                 rng(1, 20), rng(1, 10), rng(11, 20));

        // Press in the triple pulse cycle starts a fresh single.
        run_case("back_to_back", at(0) | at(5) | at(6) | at(7), 20, at(18), '0, at(7),
                 rng(1, 6) | rng(8, 17), rng(1, 5) | rng(8, 17), at(6));

        // Reset mid-group discards it.
        run_case("pre_reset", at(0) | at(2), 5, '0, '0, '0, rng(1, 5), rng(1, 2), rng(3, 5));
        #2;
        reset = 1'b1;
        #1;
        check_all("reset_async", 5, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_case("after_reset", '0, 25, '0, '0, '0, '0, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/click_classifier.md
# click_classifier

Downstream consumer of the button debouncer's single-cycle press pulses. Groups presses that arrive within a programmable inter-click window and emits exactly one classification pulse per group: single, double or triple click. Sits between each debounced button and the control FSMs, so one physical button can drive three distinct commands.

## Interface
- `WINDOW`, 30_000_000: maximum gap, in clk cycles, between consecutive presses of one group (300 ms at 100 MHz); legal range 2 to 2^32-1.
- `clk`  input  1  system clock (100 MHz).
- `reset`  input  1  asynchronous, active-high reset.
- `press`  input  1  debounced press pulse, high for exactly 1 clk per press; already synchronous to `clk`.
- `single_click`  output  1  1-clk pulse: group closed with 1 press.
- `double_click`  output  1  1-clk pulse: group closed with 2 presses.
- `triple_click`  output  1  1-clk pulse: group closed with 3 presses.
- `busy`  output  1  high while a group is open (state WAIT).
- `click_count`  output  2  presses accumulated in the open group; 0 when idle.

## Operation
- States: IDLE, WAIT. Internal: `count` (2 bits), `timer` (32 bits, unsigned).
- IDLE, `press`=1: `count`<=1, `timer`<=0, go WAIT. IDLE, `press`=0: hold.
- WAIT, `press`=1:
  - `count`==2: group closes immediately; `triple_click`<=1, `count`<=0, go IDLE (3 is the maximum; no waiting for further presses).
  - otherwise: `count`<=`count`+1, `timer`<=0, stay WAIT.
- WAIT, `press`=0, `timer`==WINDOW-1: group closes; `count`==1 gives `single_click`<=1, `count`==2 gives `double_click`<=1; `count`<=0, go IDLE.
- WAIT, `press`=0, `timer`<WINDOW-1: `timer`<=`timer`+1.
- Simultaneous press and timeout in the same cycle: the press wins. It is counted, and the timer restarts, or the group closes as triple.
- Press in the cycle in which a classification pulse is high: the state is already IDLE, so the press opens a new group and is not lost.
- At most one of the three click outputs is high in any cycle. Each pulse lasts exactly 1 clk.
- `busy` = (state==WAIT); `click_count` = `count`; both are driven directly from registers.
- The timer never wraps: it is cleared on every accepted press and the group closes at WINDOW-1.

## Timing
- Reset (async assert, sampled release): state IDLE, `count`=0, `timer`=0. All outputs are 0: `single_click`, `double_click`, `triple_click`, `busy`, `click_count`.
- Reset mid-group: the group is discarded and no pulse is emitted, including one that would have fired in the same cycle.
- All outputs are registered. The earliest response is 1 clk after the triggering `press` cycle.
- First press at cycle t: `busy`=1 and `click_count`=1 from t+1.
- Last press of a group at cycle t: a press is still accepted at any cycle up to and including t+WINDOW.
  - With no such press, the decision is made in cycle t+WINDOW.
  - The single/double pulse is high in cycle t+WINDOW+1, with `busy`=0 in that same cycle.
- Third press at cycle t: `triple_click` is high at t+1, with `busy`=0 and `click_count`=0 at t+1.

## Test plan
- WINDOW=10; one press at cycle 0 → `single_click` high only at cycle 11; `busy` high cycles 1–10; no other pulse.
- WINDOW=10; presses at 0 and 10 → second press accepted at the boundary; `double_click` only at cycle 21; `click_count` reads 1 for cycles 1–10, 2 for cycles 11–20.
- WINDOW=10; presses at 0, 3, 5 → `triple_click` at cycle 6; `busy`=0 at 6; no single/double pulse follows.
- WINDOW=10; presses at 0 and 11 → `single_click` at 11 and a new group opens at 12 (`busy`=1, `click_count`=1); `single_click` again at 22.
- WINDOW=10; presses at 0, 2, then `reset` pulsed at cycle 5 → all outputs 0 immediately; no click pulse through cycle 30.
- WINDOW=10; presses at 0, 5, 6, 7 → `triple_click` at 7; the press at 7 opens a new group; `single_click` at 18.
